apb3_completer_mem_ws: RTL

//  APB3 completer backed by a word-addressed memory, parametrised in address/data width and depth.

---
 rtl/apb3_completer_mem_ws.sv | 135 +++++++++++++
 1 files changed

// File: rtl/apb3_completer_mem_ws.sv
// APB3 completer backed by a word-addressed memory with programmable wait
// states and PSLVERR on misaligned or out-of-range accesses.
// Optional feature macro: APB3_COMPLETER_MEM_WS_RANDOM_WAIT_EN
//   defined   -> per-transfer wait count drawn from a 16-bit LFSR, 0..WaitStates
//   undefined -> every transfer waits exactly WaitStates cycles
module apb3_completer_mem_ws #(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Depth        = 1024,
  parameter int unsigned WaitStates   = 0,
  parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned Offs      = $clog2(DataWidth / 8);
  localparam int unsigned IdxWidth  = AddressWidth - Offs;
  localparam int unsigned IdxExtW   = IdxWidth + 1;
  localparam int unsigned MemAw     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned WcntWidth = 8;
  localparam logic [IdxExtW-1:0]   DepthLim = IdxExtW'(Depth);
  localparam logic [WcntWidth-1:0] WaitLoad = WcntWidth'(WaitStates);

  // Reject configurations the address decode cannot represent
  if (DataWidth < 8 || (DataWidth & (DataWidth - 1)) != 0) begin : g_bad_dw
    $error("DataWidth must be a power of two >= 8");
  end
  if (64'(Depth) > (64'(1) << IdxWidth)) begin : g_bad_depth
    $error("Depth exceeds the addressable word range");
  end
  if (WaitStates > 255) begin : g_bad_ws
    $error("WaitStates must be 0..255");
  end
  if (LfsrSeed == 16'h0000) begin : g_bad_seed
    $error("LfsrSeed must be non-zero");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                 state_q;
  logic [WcntWidth-1:0]   wcnt_q;
  logic [WcntWidth-1:0]   wcnt_load;
  logic [IdxWidth-1:0]    idx;
  logic [MemAw-1:0]       mem_addr;
  logic                   misalign;
  logic                   err;
  logic                   wr_en;
  logic [DataWidth-1:0]   mem_q [Depth];

  // Address decode: word index plus error qualification
  assign idx      = paddr[AddressWidth-1:Offs];
  assign mem_addr = MemAw'(idx);

  if (Offs == 0) begin : g_no_lsb
    assign misalign = 1'b0;
  end else begin : g_lsb
    assign misalign = |paddr[Offs-1:0];
  end

  assign err = misalign || ({1'b0, idx} >= DepthLim);

`ifdef APB3_COMPLETER_MEM_WS_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign wcnt_load = WcntWidth'(lfsr_q % 16'(WaitStates + 1));

  // LFSR advances once per transfer start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else if (state_q == IDLE && psel) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign wcnt_load = WaitLoad;
`endif

  // Transfer FSM: setup in IDLE, count down waits in ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel) begin
            state_q <= ACCESS;
            wcnt_q  <= wcnt_load;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (wcnt_q != '0) begin
            wcnt_q <= wcnt_q - WcntWidth'(1);
          end else if (penable) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion flags derived from registered state
  assign pready  = (state_q == ACCESS) && (wcnt_q == '0) && psel && penable;
  assign pslverr = pready && err;
  assign wr_en   = pready && pwrite && !err;

  // Memory write on the completing edge; array itself is not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[mem_addr] <= pwdata;
    end
  end

  // Read data only valid during a successful read completion
  assign prdata = (pready && !pwrite && !err) ? mem_q[mem_addr] : '0;

endmodule
